// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types, default widths and helpers for the compensation readout.
package comp_pkg;

  localparam int DEF_NUM_COL = 8;
  localparam int DEF_ACC_W   = 33;
  localparam int DEF_PSUM_W  = 32;
  localparam int DEF_OUT_W   = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Column counter width; a single column still needs one bit.
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp_sat_add.sv
// rtl/comp_sat_add.sv - sign-extend and add one column's psum and compensation sum.
// COMP_READOUT_SAT_EN: saturate to the signed OUT_W range; otherwise keep the low OUT_W bits.
module comp_sat_add
  import comp_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic [ACC_W-1:0]  comp_i,
  input  logic [PSUM_W-1:0] psum_i,
  output logic [OUT_W-1:0]  sum_o
);

  localparam int SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] sum;

  assign sum = {comp_i[ACC_W-1], comp_i}
             + {{(SUM_W-PSUM_W){psum_i[PSUM_W-1]}}, psum_i};

`ifdef COMP_READOUT_SAT_EN
  logic ovf;

  // The sum fits in OUT_W bits only when every bit above the OUT_W sign bit matches it.
  assign ovf = (sum[SUM_W-1:OUT_W-1] != {(SUM_W-OUT_W+1){sum[SUM_W-1]}});

  always_comb begin
    sum_o = sum[OUT_W-1:0];
    if (ovf) begin
      sum_o = sum[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^sum[SUM_W-1:OUT_W];
  assign sum_o     = sum[OUT_W-1:0];
`endif

endmodule

// File: rtl/compensation_readout.sv
// rtl/compensation_readout.sv - snapshot column compensation sums and psums, stream corrected results.
// COMP_READOUT_SAT_EN selects saturating rather than wrapping output arithmetic.
module compensation_readout
  import comp_pkg::*;
#(
  parameter int NUM_COL = DEF_NUM_COL,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int PSUM_W  = DEF_PSUM_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_COL*ACC_W-1:0]  comp_sum_in,
  input  logic [NUM_COL*PSUM_W-1:0] psum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [col_w(NUM_COL)-1:0] out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      comp_clr,
  output logic                      done
);

  localparam int COL_W = col_w(NUM_COL);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ACC_W-1:0]  snap_comp_q [NUM_COL];
  logic [PSUM_W-1:0] snap_psum_q [NUM_COL];
  logic [OUT_W-1:0]  out_data_q;
  logic [OUT_W-1:0]  sum_w;
  logic [ACC_W-1:0]  sel_comp;
  logic [PSUM_W-1:0] sel_psum;
  logic              fin_q, fin_d;
  logic              load, snap_en, is_last;

  assign is_last = (col_q == LAST_COL);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fin_d   = 1'b0;
    load    = 1'b0;
    snap_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          col_d   = '0;
          load    = 1'b1;
          snap_en = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (is_last) begin
            state_d = IDLE;
            col_d   = '0;
            fin_d   = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first beat is computed straight from the inputs, since the snapshot lands on the same edge.
  always_comb begin
    sel_comp = snap_comp_q[col_d];
    sel_psum = snap_psum_q[col_d];
    if (state_q == IDLE) begin
      sel_comp = comp_sum_in[ACC_W-1:0];
      sel_psum = psum_in[PSUM_W-1:0];
    end
  end

  comp_sat_add #(
    .ACC_W  (ACC_W),
    .PSUM_W (PSUM_W),
    .OUT_W  (OUT_W)
  ) u_sat_add (
    .comp_i (sel_comp),
    .psum_i (sel_psum),
    .sum_o  (sum_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      out_data_q <= '0;
      fin_q      <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) begin
        snap_comp_q[c] <= '0;
        snap_psum_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      fin_q   <= fin_d;
      if (load) begin
        out_data_q <= sum_w;
      end
      if (snap_en) begin
        for (int c = 0; c < NUM_COL; c++) begin
          snap_comp_q[c] <= comp_sum_in[c*ACC_W +: ACC_W];
          snap_psum_q[c] <= psum_in[c*PSUM_W +: PSUM_W];
        end
      end
    end
  end

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_last  = out_valid && is_last;
  assign out_col   = col_q;
  assign out_data  = out_data_q;
  assign done      = fin_q;
  assign comp_clr  = fin_q;

endmodule

// File: doc/compensation_readout.md
Name: compensation_readout

Overview:
Drains the per-column compensation sums held by the compensation accumulators at the bottom of the systolic array once a tile's Cal phase ends.
- On a start pulse it snapshots all NUM_COL accumulated compensation values and the matching column partial sums.
- It adds each compensation value to its column's partial sum.
- It streams the corrected results column-by-column to the output buffer over a valid/ready handshake.
- It is the consumer/reader side of the accumulators' Compensation_Sum interface.

Parameters:
- NUM_COL, 8, number of systolic columns (and accumulators) drained per tile
- ACC_W, 33, width of each compensation sum (signed two's complement)
- PSUM_W, 32, width of each column partial sum (signed)
- OUT_W, 32, width of streamed corrected result (signed)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to snapshot and drain the current tile
- comp_sum_in  in  NUM_COL*ACC_W  flat compensation sums; column c occupies bits [c*ACC_W +: ACC_W]
- psum_in  in  NUM_COL*PSUM_W  flat column partial sums; same packing as comp_sum_in
- out_valid  out  1  corrected result available
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  corrected result for the column given by out_col
- out_col  out  clog2(NUM_COL)  column index of out_data
- out_last  out  1  high with the final column's beat
- busy  out  1  high from snapshot until the last beat is accepted
- comp_clr  out  1  one-cycle pulse telling the accumulators to clear for the next tile
- done  out  1  one-cycle pulse when a drain completes

Behaviour:
- Reset: state IDLE; out_valid, out_last, busy, comp_clr and done are 0; out_data and out_col are 0; snapshot registers are 0. Reset mid-stream aborts the drain immediately. No comp_clr or done is issued for an aborted drain.
- FSM states: IDLE, STREAM.
- IDLE:
  - start=1: latch comp_sum_in and psum_in into snapshot registers, set col index to 0, go to STREAM, busy=1 from the next cycle.
  - start=0: stay in IDLE.
- STREAM:
  - out_valid=1; out_col = col index; out_data = f(snap_psum[col], snap_comp[col]); out_last = (col == NUM_COL-1).
  - Latency: first beat is valid the cycle after start is accepted.
  - Handshake on out_valid && out_ready:
    - not last: col increments and the next beat is presented the next cycle.
    - last: go to IDLE; busy, out_valid and out_last drop the next cycle; comp_clr and done pulse high for exactly that one cycle.
  - Back-pressure: while out_valid && !out_ready, out_data, out_col and out_last hold stable. Back-pressure of any length is allowed.
- start while busy: ignored. The snapshot is not disturbed and no queueing occurs.
- start in the done cycle: accepted, because the state is already IDLE. A new snapshot is taken and the stream restarts at column 0.
- Input changes after the snapshot have no effect on the current drain.
- Arithmetic:
  - Sign-extend both operands to ACC_W+1 bits (34) and add; no overflow is possible at 34 bits.
  - Reduce the sum to OUT_W bits per the Optional Feature.
- out_data is registered (launched from a flop), not a combinational path from the snapshot mux.

Optional Feature:
- Macro: COMP_READOUT_SAT_EN.
- Defined: the 34-bit sum saturates to the signed OUT_W range.
  - Above 2^(OUT_W-1)-1 gives 0x7FFFFFFF.
  - Below -2^(OUT_W-1) gives 0x80000000.
- Undefined: out_data is the low OUT_W bits of the sum (two's-complement wrap). No extra logic is instantiated.

Decomposition:
- Shared package comp_pkg holds:
  - state enum type (IDLE, STREAM)
  - default width constants ACC_W, PSUM_W, OUT_W, NUM_COL
  - column-index width function
- One sub-module: comp_sat_add. It performs the sign-extend, add and saturate-or-truncate step, selected by COMP_READOUT_SAT_EN. It is instantiated once after the column mux.

Test Plan:
1. Basic drain, out_ready=1: comp=[1,2,...,8], psum=[100,...,800], start pulse.
   - 8 consecutive beats out_data=101,202,...,808 with out_col 0..7.
   - out_last on col 7.
   - done and comp_clr pulse the cycle after beat 7.
2. Back-pressure: as in test 1, out_ready low for 3 cycles on col 2.
   - out_data=303 and out_col=2 held stable.
   - Resumes with 404 after ready returns.
3. Signed and overflow: col0 psum=0x7FFFFFFF, comp=+1.
   - SAT_EN defined: 0x7FFFFFFF.
   - SAT_EN undefined: 0x80000000.
   - col1 psum=-5, comp=-3 gives -8.
4. Snapshot isolation and start-while-busy: change inputs and pulse start during the stream.
   - Stream output is unchanged; exactly 8 beats; one done pulse.
5. Back-to-back tiles: start asserted in the done cycle.
   - Second stream begins the next cycle at col 0 with the new values.
6. Reset mid-stream at col 4: outputs zero, state IDLE, no done or comp_clr; a fresh start drains normally.
